// File: rtl/mp_addsub_seq_if.sv
// Purpose: request/response bundle for the multi-cycle wide adder/subtractor.
// Latency: none (pure wiring); timing is set by the engine behind the slave modport.
// Backpressure: busy high means start is ignored; done is a one-cycle result strobe.
interface mp_addsub_seq_if #(
  parameter int WIDTH = 1027
) ();
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH:0]   result;
  logic             lt;
  logic             busy;
  logic             done;

  modport master (
    output start, mode, in_a, in_b,
    input  result, lt, busy, done
  );

  modport slave (
    input  start, mode, in_a, in_b,
    output result, lt, busy, done
  );
endinterface

// File: rtl/mp_addsub_seq.sv
// Purpose: multi-precision add / sub / conditional-sub, CHUNK bits per cycle, LSB chunk first.
// Latency: start accepted at edge 0 -> done high in cycle CYCLES+2; back-to-back start in DONE.
// Backpressure: start ignored while busy (RUN/SEL); no queueing, operands sampled on accept only.
module mp_addsub_seq #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 128
) (
  input logic            clk,
  input logic            resetn,
  mp_addsub_seq_if.slave bus
);

  localparam int CYCLES = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int PW     = CYCLES * CHUNK;
  localparam int CW     = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, SEL, DONE} state_t;

  state_t           state, stateNext;
  logic [PW-1:0]    aSh, bSh, sumSh, sumShNext;
  logic [WIDTH-1:0] aCopy;
  logic [1:0]       modeReg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   resultReg, selResult;
  logic             ltReg, selLt;
  logic             accept, busyComb, doneComb;
  logic             subIn, subOp, addTop;
  logic [CHUNK-1:0] bChunk;
  logic [CHUNK:0]   chunkSum;

  // Modes 01 and 10 both run the datapath as a+~b+1; 11 falls back to add.
  assign subIn = (bus.mode == 2'b01) || (bus.mode == 2'b10);
  assign subOp = (modeReg == 2'b01) || (modeReg == 2'b10);

  // One CHUNK-wide slice per cycle; carry holds the inter-slice carry (seeded with sub at accept).
  assign bChunk   = subOp ? ~bSh[CHUNK-1:0] : bSh[CHUNK-1:0];
  assign chunkSum = {1'b0, aSh[CHUNK-1:0]} + {1'b0, bChunk} + {{CHUNK{1'b0}}, carry};

  // The sum shift register fills from the MSB end so chunk 0 lands at bit 0 after CYCLES shifts.
  generate
    if (CYCLES > 1) begin : gShift
      assign sumShNext = {chunkSum[CHUNK-1:0], sumSh[PW-1:CHUNK]};
    end else begin : gNoShift
      assign sumShNext = chunkSum[CHUNK-1:0];
    end
    // Add carry-out: inside the padded sum when padding exists, else the final slice carry.
    if (PW > WIDTH) begin : gTopPad
      assign addTop = sumSh[WIDTH];
    end else begin : gTopCarry
      assign addTop = carry;
    end
  endgenerate

  // Final result/lt selection from the completed sum; final carry==0 means a<b.
  always_comb begin
    selLt     = subOp & ~carry;
    selResult = {addTop, sumSh[WIDTH-1:0]};
    case (modeReg)
      2'b01:   selResult = {selLt, sumSh[WIDTH-1:0]};
      2'b10:   selResult = selLt ? {1'b0, aCopy} : {1'b0, sumSh[WIDTH-1:0]};
      default: selResult = {addTop, sumSh[WIDTH-1:0]};
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= stateNext;
  end

  // Next-state decode plus handshake outputs.
  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    busyComb  = 1'b0;
    doneComb  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        busyComb = 1'b1;
        if (cnt == LAST) stateNext = SEL;
      end
      SEL: begin
        busyComb  = 1'b1;
        stateNext = DONE;
      end
      DONE: begin
        doneComb = 1'b1;
        if (bus.start) begin
          accept    = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Operand load on accept, chunk-serial processing in RUN, result capture in SEL.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aSh       <= '0;
      bSh       <= '0;
      sumSh     <= '0;
      aCopy     <= '0;
      modeReg   <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      resultReg <= '0;
      ltReg     <= 1'b0;
    end else begin
      if (accept) begin
        aSh     <= PW'(bus.in_a);
        bSh     <= PW'(bus.in_b);
        aCopy   <= bus.in_a;
        modeReg <= bus.mode;
        carry   <= subIn;
        cnt     <= '0;
      end else if (state == RUN) begin
        aSh   <= aSh >> CHUNK;
        bSh   <= bSh >> CHUNK;
        sumSh <= sumShNext;
        carry <= chunkSum[CHUNK];
        cnt   <= cnt + CW'(1);
      end
      if (state == SEL) begin
        resultReg <= selResult;
        ltReg     <= selLt;
      end
    end
  end

  assign bus.result = resultReg;
  assign bus.lt     = ltReg;
  assign bus.busy   = busyComb;
  assign bus.done   = doneComb;

endmodule

// File: tb/tb_mp_addsub_seq.sv
// Purpose: self-checking bench for mp_addsub_seq at CHUNK=128, 1027 and 100 in lockstep.
// Latency: expects done in cycle CYCLES+2 (11, 3, 13) after the accepting edge.
// Backpressure: exercises ignored starts while busy and back-to-back start held in DONE.
module tb_mp_addsub_seq;

  localparam int W  = 1027;
  localparam int RW = W + 1;
  localparam int ND = 3;

  logic clk;
  logic resetn;
  logic start;
  logic [1:0] mode;
  logic [W-1:0] inA, inB;

  int checks   = 0;
  int failures = 0;

  mp_addsub_seq_if #(.WIDTH(W)) if0 ();
  mp_addsub_seq_if #(.WIDTH(W)) if1 ();
  mp_addsub_seq_if #(.WIDTH(W)) if2 ();

  assign if0.start = start; assign if0.mode = mode; assign if0.in_a = inA; assign if0.in_b = inB;
  assign if1.start = start; assign if1.mode = mode; assign if1.in_a = inA; assign if1.in_b = inB;
  assign if2.start = start; assign if2.mode = mode; assign if2.in_a = inA; assign if2.in_b = inB;

  mp_addsub_seq #(.WIDTH(W), .CHUNK(128))  dut0 (.clk(clk), .resetn(resetn), .bus(if0));
  mp_addsub_seq #(.WIDTH(W), .CHUNK(1027)) dut1 (.clk(clk), .resetn(resetn), .bus(if1));
  mp_addsub_seq #(.WIDTH(W), .CHUNK(100))  dut2 (.clk(clk), .resetn(resetn), .bus(if2));

  logic [W:0] resArr [ND];
  logic       ltArr  [ND];
  logic       busyArr[ND];
  logic       doneArr[ND];

  assign resArr[0] = if0.result; assign ltArr[0] = if0.lt; assign busyArr[0] = if0.busy; assign doneArr[0] = if0.done;
  assign resArr[1] = if1.result; assign ltArr[1] = if1.lt; assign busyArr[1] = if1.busy; assign doneArr[1] = if1.done;
  assign resArr[2] = if2.result; assign ltArr[2] = if2.lt; assign busyArr[2] = if2.busy; assign doneArr[2] = if2.done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int expCycle(input int i);
    case (i)
      0:       return 11;
      1:       return 3;
      default: return 13;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h..%h required=%h..%h", tag, obs[W:W-35], obs[95:0], exp[W:W-35], exp[95:0]);
    end
  endtask

  // Reference: exact integer arithmetic on WIDTH+1 bits.
  task automatic model(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W:0] r, output logic l);
    logic [W:0] ea, eb;
    ea = {1'b0, a};
    eb = {1'b0, b};
    case (m)
      2'b01:   begin r = ea - eb;                l = (a < b); end
      2'b10:   begin r = (a >= b) ? ea - eb : ea; l = (a < b); end
      default: begin r = ea + eb;                l = 1'b0;    end
    endcase
  endtask

  function automatic logic [W-1:0] rnd();
    logic [1055:0] v;
    for (int i = 0; i < 33; i++) v[i*32 +: 32] = $urandom;
    return v[W-1:0];
  endfunction

  // One operation on all DUTs; operands scrambled while busy must not matter.
  task automatic runOp(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W:0] er;
    logic       el;
    int         first [ND];
    int         cnt   [ND];
    logic [W:0] gotR  [ND];
    logic       gotL  [ND];
    logic       gotB  [ND];
    model(m, a, b, er, el);
    @(negedge clk);
    mode = m; inA = a; inB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < ND; i++) begin
      first[i] = 0; cnt[i] = 0; gotR[i] = '0; gotL[i] = 1'b0; gotB[i] = 1'b1;
      chk($sformatf("%s.d%0d.busy_c1", tag, i), RW'(busyArr[i]), RW'(1));
    end
    for (int c = 1; c <= 15; c++) begin
      for (int i = 0; i < ND; i++) begin
        if (doneArr[i]) begin
          cnt[i]++;
          if (first[i] == 0) begin
            first[i] = c; gotR[i] = resArr[i]; gotL[i] = ltArr[i]; gotB[i] = busyArr[i];
          end
        end
      end
      inA = rnd(); inB = rnd(); mode = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("%s.d%0d.done_cyc", tag, i), RW'(first[i]), RW'(expCycle(i)));
      chk($sformatf("%s.d%0d.done_cnt", tag, i), RW'(cnt[i]), RW'(1));
      chk($sformatf("%s.d%0d.busy_done", tag, i), RW'(gotB[i]), RW'(0));
      chk($sformatf("%s.d%0d.result", tag, i), gotR[i], er);
      chk($sformatf("%s.d%0d.lt", tag, i), RW'(gotL[i]), RW'(el));
      chk($sformatf("%s.d%0d.held", tag, i), resArr[i], er);
    end
  endtask

  initial begin : main
    logic [W-1:0] allOnes, one, p128, p1026, bigM, a, b;
    logic [W:0]   r1, r2, er;
    logic         l2, el;
    int           n, d1, d2;

    allOnes = '1;
    one     = 1;
    p128    = '0; p128[128] = 1'b1;
    p1026   = '0; p1026[1026] = 1'b1;
    bigM    = p1026 | one;

    resetn = 1'b0; start = 1'b0; mode = 2'b00; inA = '0; inB = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("rst.d%0d.result", i), resArr[i], '0);
      chk($sformatf("rst.d%0d.flags", i), RW'({ltArr[i], busyArr[i], doneArr[i]}), RW'(0));
    end
    resetn = 1'b1;
    @(negedge clk);

    runOp(2'b00, allOnes, one, "add_all1");
    runOp(2'b00, p128 - one, one, "add_c128");
    runOp(2'b01, p128, one, "sub_c128");
    runOp(2'b01, W'(5), W'(7), "sub_5_7");
    runOp(2'b01, p1026, p1026, "sub_eq");
    runOp(2'b10, bigM + W'(3), bigM, "csub_ge");
    runOp(2'b10, W'(3), bigM, "csub_lt");
    runOp(2'b10, bigM, bigM, "csub_eq");
    runOp(2'b11, W'(12345), W'(678), "mode11");
    runOp(2'b11, allOnes, allOnes, "mode11_max");

    for (int k = 0; k < 12; k++) begin
      a = rnd();
      case ($urandom_range(0, 3))
        0:       b = rnd();
        1:       b = a;
        2:       b = a + one;
        default: b = a >> $urandom_range(0, W - 1);
      endcase
      runOp(2'($urandom_range(0, 3)), a, b, $sformatf("rand%0d", k));
    end

    // Start re-pulsed in cycles 3..10 while busy: exactly one done, first operands used.
    @(negedge clk);
    mode = 2'b00; inA = W'(10); inB = W'(20); start = 1'b1;
    @(negedge clk);
    start = 1'b0; n = 0; d1 = 0; r1 = '0;
    for (int c = 1; c <= 20; c++) begin
      start = (c >= 3 && c <= 10);
      if (start) begin inA = rnd(); inB = rnd(); mode = 2'($urandom_range(0, 3)); end
      if (if0.done) begin n++; if (d1 == 0) begin d1 = c; r1 = if0.result; end end
      @(negedge clk);
    end
    start = 1'b0;
    chk("repulse.done_cnt", RW'(n), RW'(1));
    chk("repulse.done_cyc", RW'(d1), RW'(11));
    chk("repulse.result", r1, RW'(30));

    // Start held into DONE: second op accepted back-to-back, done in cycle 22.
    @(negedge clk);
    mode = 2'b00; inA = W'(100); inB = W'(200); start = 1'b1;
    @(negedge clk);
    mode = 2'b01; inA = W'(50); inB = W'(70);
    n = 0; d1 = 0; d2 = 0; r1 = '0; r2 = '0; l2 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      start = (c <= 11);
      if (if0.done) begin
        n++;
        if (d1 == 0) begin d1 = c; r1 = if0.result; end
        else if (d2 == 0) begin d2 = c; r2 = if0.result; l2 = if0.lt; end
      end
      @(negedge clk);
    end
    start = 1'b0;
    model(2'b01, W'(50), W'(70), er, el);
    chk("b2b.done_cnt", RW'(n), RW'(2));
    chk("b2b.done1_cyc", RW'(d1), RW'(11));
    chk("b2b.result1", r1, RW'(300));
    chk("b2b.done2_cyc", RW'(d2), RW'(22));
    chk("b2b.result2", r2, er);
    chk("b2b.lt2", RW'(l2), RW'(el));
    repeat (30) @(negedge clk);

    // Async reset in RUN cycle 4: everything clears before the next edge, no done follows.
    @(negedge clk);
    mode = 2'b00; inA = W'(5); inB = W'(6); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("arst.d0.result", if0.result, '0);
    chk("arst.d0.flags", RW'({if0.lt, if0.busy, if0.done}), RW'(0));
    chk("arst.d1.result", if1.result, '0);
    chk("arst.d2.busy", RW'(if2.busy), RW'(0));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    n = 0;
    for (int c = 0; c < 15; c++) begin
      if (if0.done || if1.done || if2.done) n++;
      @(negedge clk);
    end
    chk("arst.no_done", RW'(n), RW'(0));
    runOp(2'b00, W'(1), W'(2), "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
